imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory read port used by the pipelined core. Accepts a byte stream
//  over a valid/ready handshake and packs it into 32-bit instruction words. Writes the words into
//  instruction memory at sequential word addresses starting at 0.
//  Holds the core in reset from power-up until a complete program has been written.
// PARAMETERS
//  ADDR_W   8   instruction-memory word address width (matches core PC width)
//  INSTR_W  32  instruction word width; must be a multiple of 8
//  BYTE_W   8   stream symbol width
// PORTS
//  clk_i         in   1        single clock, rising edge
//  rst_i         in   1        reset, asynchronous, active-high
//  start_i       in   1        1-cycle pulse: begin a load; sampled only in IDLE
//  len_i         in   ADDR_W+1 program length in words (1..2**ADDR_W); captured on accepted start_i
//  s_data_i      in   BYTE_W   stream byte
//  s_valid_i     in   1        stream byte valid
//  s_ready_o     out  1        loader can accept a byte
//  imem_we_o     out  1        instruction-memory write enable
//  imem_addr_o   out  ADDR_W   instruction-memory word address
//  imem_wdata_o  out  INSTR_W  instruction-memory write data
//  cpu_rst_o     out  1        reset to core (drives core rst_i)
//  busy_o        out  1        load in progress
//  done_o        out  1        1-cycle pulse: last word written
//  err_o         out  1        1-cycle pulse: start_i rejected (len_i==0 or len_i>2**ADDR_W)
// BEHAVIOUR
//  Reset: FSM=IDLE, word/byte counters=0, packer cleared; s_ready_o=0, imem_we_o=0, imem_addr_o=0,
//   imem_wdata_o=0, busy_o=0, done_o=0, err_o=0, cpu_rst_o=1.
//  FSM states: IDLE, RECV, WRITE, DONE.
//   IDLE:  start_i with valid len -> RECV; capture len, word_cnt=0, byte_cnt=0, cpu_rst_o=1.
//          start_i with invalid len -> err_o=1 next cycle; stay IDLE; cpu_rst_o unchanged.
//   RECV:  s_ready_o=1; byte accepted when s_valid_i&&s_ready_o. Little-endian: byte k -> bits
//          [8k+7:8k]. When the INSTR_W/8-th byte is accepted -> WRITE.
//   WRITE: s_ready_o=0; imem_we_o=1 for exactly one cycle, imem_addr_o=word_cnt, imem_wdata_o=packed
//          word. Then word_cnt++. If word_cnt+1==len -> DONE, else -> RECV with byte_cnt=0.
//   DONE:  done_o=1 for one cycle; cpu_rst_o=0 from this cycle onward; -> IDLE.
//  busy_o=1 in RECV/WRITE/DONE. start_i outside IDLE is ignored (no err_o).
//  Throughput: 1 word per (INSTR_W/8 + 1) cycles when s_valid_i held high.
//  Latency: last byte accepted at cycle t -> imem_we_o at t+1 -> done_o at t+2 -> core out of reset at t+2.
//  Counter widths: word_cnt ADDR_W+1 bits; len=2**ADDR_W loads full memory with no address wrap;
//   imem_addr_o = word_cnt[ADDR_W-1:0].
//  s_valid_i low mid-word: hold partial word and byte_cnt indefinitely (no timeout).
//  rst_i mid-load: immediate return to reset values; partial word discarded; words already written
//   stay in memory; cpu_rst_o=1 until the next complete load.
//  Re-load after DONE: start_i re-asserts cpu_rst_o the cycle after acceptance. Core is held in reset
//   for the entire reload.
//  imem_wdata_o holds its last value when imem_we_o=0.
// STRUCTURE
//  Shared include loader_defs.vh: FSM state encodings (LD_IDLE, LD_RECV, LD_WRITE, LD_DONE),
//   BYTES_PER_WORD = INSTR_W/BYTE_W.
//  Sub-module byte_packer: shift-in register plus byte counter. Ports: clk_i, rst_i, clr_i, push_i,
//   byte_i, word_o, full_o.
//  Top: FSM, word counter, length register, output registers. All outputs are registered.
// TESTING
//  1. Reset release, no start -> cpu_rst_o=1, s_ready_o=0, imem_we_o=0 for 100 cycles.
//  2. len=2, bytes 13 00 00 00 93 00 10 00 back-to-back -> writes 0x00000013 @0 and 0x00100093 @1;
//     exactly 2 we pulses; done_o 1 cycle after second we; cpu_rst_o falls with done_o.
//  3. len=1, s_valid_i toggled 1-0-0-1 between bytes -> single correct word; no we before 4th byte;
//     s_ready_o stays 1 in RECV.
//  4. len=0 and len=257 -> err_o pulse each; FSM stays IDLE; no writes; cpu_rst_o unchanged.
//  5. len=256, random data -> addresses 0..255 each written once, no wrap; done_o once;
//     readback via inst_memory matches.
//  6. rst_i asserted after 2 bytes of word 3 -> outputs at reset values asynchronously; cpu_rst_o=1;
//     fresh len=1 load after release writes @0 correctly.
//  7. start_i pulsed during RECV -> ignored: len unchanged, no err_o, load completes normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM state encodings and word/byte geometry helper.
package imem_loader_pkg;
  typedef enum logic [1:0] {LD_IDLE, LD_RECV, LD_WRITE, LD_DONE} ld_state_t;
  function automatic int bytes_per_word(input int instr_w, input int byte_w);
    return instr_w / byte_w;
  endfunction
endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: little-endian shift-in word assembler with byte counter.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int BYTE_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic [BYTE_W-1:0]  byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               full_o
);
  localparam int BPW = bytes_per_word(INSTR_W, BYTE_W);
  localparam int CW = $clog2(BPW + 1);
  logic [CW-1:0] cnt;
  logic [INSTR_W-1:0] sh;
  // word_o already includes byte_i so the completing push can be written the next cycle
  assign word_o = {byte_i, sh[INSTR_W-1:BYTE_W]};
  assign full_o = cnt == CW'(BPW - 1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i || clr_i) begin
      cnt <= '0;
      sh  <= '0;
    end else if (push_i) begin
      sh  <= word_o;
      cnt <= full_o ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into instruction words, writes them from address 0, holds the core in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int BYTE_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [ADDR_W:0]    len_i,
  input  logic [BYTE_W-1:0]  s_data_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  output logic               imem_we_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic [INSTR_W-1:0] imem_wdata_o,
  output logic               cpu_rst_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = 1;
  ld_state_t state;
  logic [ADDR_W:0] len, word_cnt, cnt_nx;
  logic [INSTR_W-1:0] word;
  logic push, last, len_ok, clr;
  assign push   = state == LD_RECV && s_valid_i && s_ready_o;
  assign len_ok = len_i != '0 && len_i <= MAX_LEN;
  assign clr    = state == LD_IDLE && start_i && len_ok;
  assign cnt_nx = word_cnt + ONE;
  imem_loader_byte_packer #(.INSTR_W(INSTR_W), .BYTE_W(BYTE_W)) u_packer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr),
    .push_i(push),
    .byte_i(s_data_i),
    .word_o(word),
    .full_o(last)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state        <= LD_IDLE;
      len          <= '0;
      word_cnt     <= '0;
      s_ready_o    <= 1'b0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      cpu_rst_o    <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      imem_we_o <= 1'b0;
      case (state)
        LD_IDLE:
          if (start_i) begin
            if (len_ok) begin
              state     <= LD_RECV;
              len       <= len_i;
              word_cnt  <= '0;
              s_ready_o <= 1'b1;
              busy_o    <= 1'b1;
              cpu_rst_o <= 1'b1;
            end else err_o <= 1'b1;
          end
        LD_RECV:
          if (push && last) begin
            state        <= LD_WRITE;
            s_ready_o    <= 1'b0;
            imem_we_o    <= 1'b1;
            imem_addr_o  <= word_cnt[ADDR_W-1:0];
            imem_wdata_o <= word;
          end
        LD_WRITE: begin
          word_cnt <= cnt_nx;
          if (cnt_nx == len) begin
            state     <= LD_DONE;
            done_o    <= 1'b1;
            cpu_rst_o <= 1'b0;
          end else begin
            state     <= LD_RECV;
            s_ready_o <= 1'b1;
          end
        end
        LD_DONE: begin
          state  <= LD_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the instruction-memory loader with a bench-side memory model.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  len = '0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, imem_we, cpu_rst, busy, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  int vecs = 0, errs = 0;
  logic [31:0] mem [256];
  logic [31:0] expw [256];
  int wr_cnt [256];
  int we_n, done_n, err_n, ord_err, cyc, we_cyc, done_cyc;
  logic rst_at_done;

  imem_loader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .len_i       (len),
    .s_data_i    (s_data),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_wdata_o(imem_wdata),
    .cpu_rst_o   (cpu_rst),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (imem_we) begin
      if (int'(imem_addr) != we_n) ord_err++;
      mem[imem_addr] = imem_wdata;
      wr_cnt[imem_addr]++;
      we_n++;
      we_cyc = cyc;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
      rst_at_done = cpu_rst;
    end
    if (err) err_n++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_stats();
    we_n = 0;
    done_n = 0;
    err_n = 0;
    ord_err = 0;
    foreach (wr_cnt[i]) wr_cnt[i] = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int k;
    logic hs;
    k = 0;
    s_valid = 1'b1;
    s_data = b;
    do begin
      hs = s_ready;
      step(1);
      k++;
    end while (!hs && k < 20);
    if (!hs) chk("send_timeout", 32'(hs), 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i+:8]);
  endtask

  task automatic start_load(input logic [8:0] l);
    start = 1'b1;
    len = l;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_n == 0 && k < 100) begin
      step(1);
      k++;
    end
    chk("done_seen", 32'(done_n > 0), 32'd1);
  endtask

  initial begin
    int bad;
    clr_stats();
    #12;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("rst_addr_wdata", imem_wdata | 32'(imem_addr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    repeat (100) begin
      step(1);
      if (cpu_rst !== 1'b1 || s_ready !== 1'b0 || imem_we !== 1'b0) bad++;
    end
    chk("idle_100_cycles", bad, 0);

    // two words back-to-back
    clr_stats();
    start_load(9'd2);
    chk("t2_ready", 32'(s_ready), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    wait_done();
    chk("t2_we_pulses", we_n, 2);
    chk("t2_mem0", mem[0], 32'h0000_0013);
    chk("t2_mem1", mem[1], 32'h0010_0093);
    chk("t2_ord", ord_err, 0);
    chk("t2_done_lat", done_cyc - we_cyc, 1);
    chk("t2_done_once", done_n, 1);
    chk("t2_cpu_rst_at_done", 32'(rst_at_done), 32'd0);
    chk("t2_cpu_rst_after", 32'(cpu_rst), 32'd0);
    chk("t2_wdata_hold", imem_wdata, 32'h0010_0093);
    chk("t2_busy_idle", 32'(busy), 32'd0);

    // valid gaps mid-word
    clr_stats();
    start_load(9'd1);
    chk("t3_reload_cpu_rst", 32'(cpu_rst), 32'd1);
    send(8'hEF);
    step(2);
    chk("t3_ready_gap1", 32'(s_ready), 32'd1);
    send(8'hBE);
    step(2);
    send(8'hAD);
    step(2);
    chk("t3_no_early_we", we_n, 0);
    chk("t3_ready_gap3", 32'(s_ready), 32'd1);
    send(8'hDE);
    wait_done();
    chk("t3_we_pulses", we_n, 1);
    chk("t3_mem0", mem[0], 32'hDEAD_BEEF);
    chk("t3_cpu_rst", 32'(cpu_rst), 32'd0);

    // invalid lengths
    clr_stats();
    step(2);
    start_load(9'd0);
    chk("t4_err_len0", 32'(err), 32'd1);
    chk("t4_busy_len0", 32'(busy), 32'd0);
    chk("t4_ready_len0", 32'(s_ready), 32'd0);
    step(1);
    chk("t4_err_pulse", 32'(err), 32'd0);
    start_load(9'd257);
    chk("t4_err_len257", 32'(err), 32'd1);
    chk("t4_busy_len257", 32'(busy), 32'd0);
    step(2);
    chk("t4_err_count", err_n, 2);
    chk("t4_no_writes", we_n, 0);
    chk("t4_cpu_rst_kept", 32'(cpu_rst), 32'd0);

    // full memory load
    clr_stats();
    foreach (expw[i]) expw[i] = $urandom;
    start_load(9'd256);
    for (int i = 0; i < 256; i++) send_word(expw[i]);
    wait_done();
    bad = 0;
    for (int i = 0; i < 256; i++) if (wr_cnt[i] != 1 || mem[i] !== expw[i]) bad++;
    chk("t5_readback", bad, 0);
    chk("t5_order", ord_err, 0);
    chk("t5_we_pulses", we_n, 256);
    chk("t5_done_once", done_n, 1);
    chk("t5_last_addr", 32'(imem_addr), 32'd255);
    chk("t5_last_wdata", imem_wdata, expw[255]);
    chk("t5_cpu_rst", 32'(cpu_rst), 32'd0);

    // reset mid-load
    clr_stats();
    start_load(9'd5);
    for (int i = 1; i <= 3; i++) send_word(32'hA000_0000 + 32'(i));
    send(8'h55);
    send(8'h66);
    #2 rst = 1'b1;
    #1;
    chk("t6_ready", 32'(s_ready), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t6_we", 32'(imem_we), 32'd0);
    chk("t6_addr", 32'(imem_addr), 32'd0);
    chk("t6_wdata", imem_wdata, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    step(1);
    chk("t6_written_before", we_n, 3);
    chk("t6_mem2_kept", mem[2], 32'hA000_0003);
    chk("t6_cpu_rst_held", 32'(cpu_rst), 32'd1);
    clr_stats();
    start_load(9'd1);
    send_word(32'h4433_2211);
    wait_done();
    chk("t6_reload_mem0", mem[0], 32'h4433_2211);
    chk("t6_mem1_kept", mem[1], 32'hA000_0002);
    chk("t6_reload_we", we_n, 1);
    chk("t6_cpu_rst_release", 32'(cpu_rst), 32'd0);

    // start during RECV is ignored
    clr_stats();
    start_load(9'd2);
    send(8'h01);
    send(8'h02);
    start = 1'b1;
    len = 9'd0;
    step(1);
    start = 1'b0;
    chk("t7_no_err", 32'(err), 32'd0);
    send(8'h03);
    send(8'h04);
    send_word(32'h0BAD_F00D);
    wait_done();
    chk("t7_err_count", err_n, 0);
    chk("t7_we_pulses", we_n, 2);
    chk("t7_mem0", mem[0], 32'h0403_0201);
    chk("t7_mem1", mem[1], 32'h0BAD_F00D);
    chk("t7_done_once", done_n, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
